// File: rtl/vector_mem_seq_pkg.sv
// Shared types for the vector load/store sequencer.
// FSM state encoding and vector element slice helper.
package vms_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   function automatic int unsigned elem_lo(
      input int unsigned k,
      input int unsigned dw
   );
      return k * dw;
   endfunction

endpackage

// File: rtl/vector_mem_seq_if.sv
// Single-port memory bus between the sequencer (master)
// and the memory (slave).
interface vector_mem_seq_if #(
   parameter int AW = 16,
   parameter int DW = 16
);
   logic [AW-1:0] Addr;
   logic          RD;
   logic          WR;
   logic [DW-1:0] dataOut;
   logic [DW-1:0] DataIn;

   modport master (
      output Addr, RD, WR, dataOut,
      input  DataIn
   );

   modport slave (
      input  Addr, RD, WR, dataOut,
      output DataIn
   );
endinterface

// File: rtl/vector_mem_seq_addr_gen.sv
// Element address accumulator with carry-out wrap pulse.
// VMS_STRIDE_EN selects programmable stride, else unit step.
module vms_addr_gen #(
   parameter int AW = 16
) (
   input  logic          Clk1,
   input  logic          Reset,
   input  logic          load,
   input  logic [AW-1:0] base,
   input  logic          step,
   input  logic [AW-1:0] stride,
   output logic [AW-1:0] addr,
   output logic          wrap
);

   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] inc;
   logic [AW:0]   sum;

`ifdef VMS_STRIDE_EN
   assign inc = stride;
`else
   // unit-stride build: stride is read but masked off
   assign inc = AW'(1) | (stride & {AW{1'b0}});
`endif

   assign sum  = {1'b0, addr_q} + {1'b0, inc};
   assign wrap = step & sum[AW];
   assign addr = addr_q;

   always_comb begin
      addr_d = addr_q;
      if (load)
         addr_d = base;
      else if (step)
         addr_d = sum[AW-1:0];
   end

   always_ff @(posedge Clk1) begin
      if (Reset)
         addr_q <= '0;
      else
         addr_q <= addr_d;
   end

endmodule

// File: rtl/vector_mem_seq.sv
// Vector load/store sequencer: one vector per command over a
// single-port bus. Optional stride via VMS_STRIDE_EN.
module vector_mem_seq #(
   parameter int ELEMS = 16,
   parameter int DW    = 16,
   parameter int AW    = 16,
   parameter int LW    = $clog2(ELEMS + 1)
) (
   input  logic               Clk1,
   input  logic               Reset,
   input  logic               start,
   input  logic               is_store,
   input  logic [AW-1:0]      base_addr,
   input  logic [AW-1:0]      stride,
   input  logic [LW-1:0]      len,
   input  logic [ELEMS*DW-1:0] st_vec,
   vector_mem_seq_if.master   bus,
   output logic               busy,
   output logic               done,
   output logic [ELEMS*DW-1:0] ld_vec,
   output logic               V
);
   import vms_pkg::*;

   localparam int VW = ELEMS * DW;
   localparam int IW = $clog2(VW);

   state_e        state_q, state_d;
   logic          is_store_q, is_store_d;
   logic [LW-1:0] len_q, len_d;
   logic [AW-1:0] stride_q, stride_d;
   logic [VW-1:0] st_q, st_d;
   logic [LW-1:0] k_q, k_d;
   logic          cap_q, cap_d;
   logic [LW-1:0] cap_k_q, cap_k_d;
   logic [VW-1:0] ld_q, ld_d;
   logic          v_q, v_d;

   logic          ag_load, ag_step, ag_wrap;
   logic [AW-1:0] ag_addr;
   logic          rd, wr, last;
   logic [LW-1:0] len_c;
   logic [IW-1:0] wr_lo, cap_lo;

   vms_addr_gen #(.AW(AW)) u_addr_gen (
      .Clk1   (Clk1),
      .Reset  (Reset),
      .load   (ag_load),
      .base   (base_addr),
      .step   (ag_step),
      .stride (stride_q),
      .addr   (ag_addr),
      .wrap   (ag_wrap)
   );

   assign len_c  = (len > LW'(ELEMS)) ? LW'(ELEMS) : len;
   assign last   = (k_q == len_q - LW'(1));
   assign wr_lo  = IW'(elem_lo(32'(k_q), DW));
   assign cap_lo = IW'(elem_lo(32'(cap_k_q), DW));

   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      len_d      = len_q;
      stride_d   = stride_q;
      st_d       = st_q;
      k_d        = k_q;
      ld_d       = ld_q;
      v_d        = v_q | ag_wrap;
      ag_load    = 1'b0;
      ag_step    = 1'b0;
      rd         = 1'b0;
      wr         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               is_store_d = is_store;
               len_d      = len_c;
               stride_d   = stride;
               st_d       = st_vec;
               k_d        = '0;
               ld_d       = '0;
               v_d        = 1'b0;
               ag_load    = 1'b1;
               state_d    = (len_c == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            rd = ~is_store_q;
            wr = is_store_q;
            if (last) begin
               state_d = is_store_q ? DONE : DRAIN;
            end else begin
               k_d     = k_q + LW'(1);
               ag_step = 1'b1;
            end
         end
         DRAIN: state_d = DONE;
         DONE:  state_d = IDLE;
      endcase

      // read data returns one cycle after its strobe
      if (cap_q)
         ld_d[cap_lo +: DW] = bus.DataIn;
   end

   assign cap_d   = rd;
   assign cap_k_d = k_q;

   always_ff @(posedge Clk1) begin
      if (Reset) begin
         state_q    <= IDLE;
         is_store_q <= 1'b0;
         len_q      <= '0;
         stride_q   <= '0;
         st_q       <= '0;
         k_q        <= '0;
         cap_q      <= 1'b0;
         cap_k_q    <= '0;
         ld_q       <= '0;
         v_q        <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         len_q      <= len_d;
         stride_q   <= stride_d;
         st_q       <= st_d;
         k_q        <= k_d;
         cap_q      <= cap_d;
         cap_k_q    <= cap_k_d;
         ld_q       <= ld_d;
         v_q        <= v_d;
      end
   end

   assign bus.RD      = rd;
   assign bus.WR      = wr;
   assign bus.Addr    = (rd | wr) ? ag_addr : '0;
   assign bus.dataOut = wr ? st_q[wr_lo +: DW] : '0;

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign ld_vec = ld_q;
   assign V      = v_q;

endmodule

// File: doc/vector_mem_seq.md
Name: vector_mem_seq

Overview:
- Parametrised vector load/store sequencer; next generation of the CVP14 VLD/VST multi-cycle path, split out as a standalone unit.
- Moves one vector per command between the register-file data path and the single-port 16-bit memory bus.
- Adds configurable element count/width, variable length, programmable stride and address-wrap flagging.
- Sits between the core control FSM (start/busy/done) and the memory bus (Addr/RD/WR/dataOut/DataIn).

Parameters:
- ELEMS, 16, max elements per vector
- DW, 16, element/bus data width in bits
- AW, 16, memory address width
- LW, $clog2(ELEMS+1), width of len

Ports:
- Clk1  in  1  clock; all state changes on posedge
- Reset  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- is_store  in  1  1 = store (VST), 0 = load (VLD); sampled with start
- base_addr  in  AW  first element address
- stride  in  AW  element address increment, unsigned
- len  in  LW  element count; values > ELEMS clamp to ELEMS
- st_vec  in  ELEMS*DW  store source; element k at [k*DW +: DW]; latched at start
- DataIn  in  DW  memory read data, valid the cycle after RD
- Addr  out  AW  memory address
- RD  out  1  memory read strobe
- WR  out  1  memory write strobe
- dataOut  out  DW  memory write data, valid with WR
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle completion pulse
- ld_vec  out  ELEMS*DW  assembled load vector; stable from done until next accepted start
- V  out  1  sticky address-wrap flag for current/last command

Behaviour:
- Reset (any state, mid-command included): next edge forces IDLE; Addr, RD, WR, dataOut, busy, done, V, ld_vec all 0; an in-flight command is dropped without further bus activity.
- States: IDLE -> ISSUE -> (load: DRAIN) -> DONE -> IDLE.
- IDLE: start=1 latches is_store, base_addr, stride, clamped len, st_vec; clears V, ld_vec, element counter k. Go to ISSUE, or DONE directly when len==0 (no bus activity).
- ISSUE, one element per cycle, k = 0..N-1: Addr = base_addr + k*stride mod 2^AW, built by accumulator, no multiplier. Load asserts RD; store asserts WR with dataOut = element k. After k==N-1: load -> DRAIN, store -> DONE.
- Load capture: DataIn in the cycle after RD for element k is written to ld_vec element k. Captures for k<N-1 overlap ISSUE. DRAIN captures element N-1, with RD=0.
- Elements >= N in ld_vec read 0.
- DONE: done=1 and busy=1 for one cycle, RD=WR=0, then IDLE.
- Latency, start sampled at edge 0:
  - load strobes in cycles 1..N, DRAIN N+1, done N+2
  - store strobes in cycles 1..N, done N+1
  - len==0: done at cycle 1
- Strobes: RD and WR never high together. Addr and dataOut are 0 when no strobe is active.
- V: set when any accumulator step carries out of AW bits (address wrapped); stays set until next accepted start or Reset. Wrapped addresses are still issued.
- start while busy (including the DONE cycle) is ignored. Back-to-back commands: earliest next acceptance is the cycle after DONE.

Optional Feature:
- Macro VMS_STRIDE_EN.
- Defined: stride port honoured as above.
- Undefined: stride port present but ignored; increment fixed at 1, which is legacy unit-stride behaviour. V still reports wrap past 2^AW-1.

Decomposition:
- Package vms_pkg: state enum (IDLE, ISSUE, DRAIN, DONE), state width localparam, element slice helper function.
- Sub-module vms_addr_gen: AW-bit accumulator.
  - Inputs: load base, step enable, stride.
  - Outputs: current address, wrap pulse.
  - Owns stride mux under VMS_STRIDE_EN.
- Capture, strobe and FSM logic stay in vector_mem_seq.

Test Plan:
- Load, base 0x0100, stride 1, len 16, memory[a]=a -> RD cycles 1..16 at 0x0100..0x010F; done at cycle 18; ld_vec element k = 0x0100+k; V=0.
- Store, base 0x2000, stride 4, len 3, st_vec elements 0xAAAA/0xBBBB/0xCCCC -> WR at 0x2000, 0x2004, 0x2008 with matching data; done at cycle 4.
  - With VMS_STRIDE_EN undefined: addresses 0x2000..0x2002.
- Load, base 0xFFFE, stride 1, len 4 -> Addr 0xFFFE, 0xFFFF, 0x0000, 0x0001; V=1 after the third issue, held until next start.
- len=0 load -> no RD/WR; done at cycle 1; ld_vec all zero.
- len=20 with ELEMS=16 -> clamped to 16 transfers.
- Reset asserted at cycle 5 of a len-16 load, then second start issued while busy -> next cycle all outputs 0, no further RD; start ignored while busy, accepted only from IDLE.
